// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a one-hot winner output and a ready/valid handshake to downstream.
// Optional grant locking is enabled with macro RR_ONEHOT_ARB_LOCK_EN; it holds a stalled winner until it transfers.
module rr_onehot_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] search_oh;
    logic [NUM_REQ-1:0] win_oh;
    logic               found;
    logic               xfer;

    // The first pass covers indices at or above the pointer; the second pass wraps around to the low indices.
    always_comb begin
        search_oh = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[k] && (PTR_W'(k) >= ptr_q)) begin
                search_oh[k] = 1'b1;
                found        = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[k]) begin
                search_oh[k] = 1'b1;
                found        = 1'b1;
            end
        end
    end

`ifdef RR_ONEHOT_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock_q, lock_d;

    assign win_oh = (|lock_q) ? lock_q : search_oh;

    always_comb begin
        lock_d = lock_q;
        if (xfer) begin
            lock_d = '0;
        end else if (valid_o) begin
            lock_d = win_oh;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign win_oh = search_oh;
`endif

    assign onehot_o = win_oh;
    assign valid_o  = |win_oh;
    assign xfer     = valid_o & ready_i;
    assign gnt_o    = xfer ? win_oh : '0;

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
                win_idx = PTR_W'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Directed bench for rr_onehot_arb (NUM_REQ=4); lock expectations follow RR_ONEHOT_ARB_LOCK_EN.
module tb_rr_onehot_arb;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] onehot_o;

    int n_cmp = 0;
    int n_err = 0;

    rr_onehot_arb #(.NUM_REQ(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .onehot_o (onehot_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = 4'b0000; ready_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 4'b0000; ready_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        sample();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_cmp++; if (onehot_o !== 4'b0000) begin n_err++; $display("FAIL reset_onehot got=%b exp=0000", onehot_o); end
        n_cmp++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
        n_cmp++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q); end
        step();
        req_i = 4'b1111;
        sample();
        n_cmp++; if (onehot_o !== 4'b0001) begin n_err++; $display("FAIL reset_prio got=%b exp=0001", onehot_o); end
        n_cmp++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL reset_nogrant got=%b exp=0000", gnt_o); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_i = 4'b1111; ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            n_cmp++; if (gnt_o !== exp_g[i]) begin n_err++; $display("FAIL rotation_gnt[%0d] got=%b exp=%b", i, gnt_o, exp_g[i]); end
            step();
        end
        n_cmp++; if (dut.ptr_q !== 2'd1) begin n_err++; $display("FAIL rotation_ptr got=%0d exp=1", dut.ptr_q); end
    endtask

    task automatic test_sparse();
        logic [3:0] exp_g [3] = '{4'b0010, 4'b1000, 4'b0010};
        do_reset();
        req_i = 4'b1010; ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++; if (gnt_o !== exp_g[i]) begin n_err++; $display("FAIL sparse_gnt[%0d] got=%b exp=%b", i, gnt_o, exp_g[i]); end
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_i = 4'b0100; ready_i = 1'b1;
        step();
        n_cmp++; if (dut.ptr_q !== 2'd3) begin n_err++; $display("FAIL wrap_ptr3 got=%0d exp=3", dut.ptr_q); end
        req_i = 4'b0011;
        sample();
        n_cmp++; if (onehot_o !== 4'b0001) begin n_err++; $display("FAIL wrap_onehot got=%b exp=0001", onehot_o); end
        n_cmp++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt got=%b exp=0001", gnt_o); end
        step();
        n_cmp++; if (dut.ptr_q !== 2'd1) begin n_err++; $display("FAIL wrap_ptr1 got=%0d exp=1", dut.ptr_q); end
    endtask

    task automatic test_lock();
        logic [3:0] exp_hold;
        logic [1:0] exp_ptr;
`ifdef RR_ONEHOT_ARB_LOCK_EN
        exp_hold = 4'b0100; exp_ptr = 2'd3;
`else
        exp_hold = 4'b0001; exp_ptr = 2'd1;
`endif
        do_reset();
        req_i = 4'b0100; ready_i = 1'b0;
        sample();
        n_cmp++; if (onehot_o !== 4'b0100) begin n_err++; $display("FAIL lock_first got=%b exp=0100", onehot_o); end
        step();
        req_i = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            sample();
            n_cmp++; if (onehot_o !== exp_hold) begin n_err++; $display("FAIL lock_hold[%0d] got=%b exp=%b", i, onehot_o, exp_hold); end
            n_cmp++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL lock_nogrant[%0d] got=%b exp=0000", i, gnt_o); end
            step();
        end
        ready_i = 1'b1;
        sample();
        n_cmp++; if (gnt_o !== exp_hold) begin n_err++; $display("FAIL lock_gnt got=%b exp=%b", gnt_o, exp_hold); end
        step();
        n_cmp++; if (dut.ptr_q !== exp_ptr) begin n_err++; $display("FAIL lock_ptr got=%0d exp=%0d", dut.ptr_q, exp_ptr); end
        req_i = 4'b0000; ready_i = 1'b0;
        sample();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL lock_released got=%b exp=0", valid_o); end
    endtask

    task automatic test_reset_xfer();
        do_reset();
        req_i = 4'b0001; ready_i = 1'b1;
        step();
        req_i = 4'b0100; ready_i = 1'b0;
        step();
        rst_i = 1'b1; ready_i = 1'b1;
        sample();
        n_cmp++; if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL rstx_gnt got=%b exp=0100", gnt_o); end
        step();
        rst_i = 1'b0; req_i = 4'b0000; ready_i = 1'b0;
        sample();
        n_cmp++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL rstx_ptr got=%0d exp=0", dut.ptr_q); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstx_lockclr got=%b exp=0", valid_o); end
        step();
        req_i = 4'b1111; ready_i = 1'b1;
        sample();
        n_cmp++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL rstx_next got=%b exp=0001", gnt_o); end
        step();
    endtask

    task automatic test_idle();
        do_reset();
        req_i = 4'b0010; ready_i = 1'b1;
        step();
        req_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, valid_o); end
            n_cmp++; if (onehot_o !== 4'b0000) begin n_err++; $display("FAIL idle_onehot[%0d] got=%b exp=0000", i, onehot_o); end
            n_cmp++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL idle_gnt[%0d] got=%b exp=0000", i, gnt_o); end
            step();
            n_cmp++; if (dut.ptr_q !== 2'd2) begin n_err++; $display("FAIL idle_ptr[%0d] got=%0d exp=2", i, dut.ptr_q); end
        end
    endtask

    initial begin
        rst_i = 1'b1; req_i = 4'b0000; ready_i = 1'b0;
        test_reset();
        test_rotation();
        test_sparse();
        test_wrap();
        test_lock();
        test_reset_xfer();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
